mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk, rising-edge; reset SHALL be rst, asynchronous, active-high.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk     in   1  clock
  rst     in   1  async active-high reset
  req     in   1  host command request, sampled on clk rising edge while busy=0
  cmd     in   2  00 read, 01 write, 10 clear-all, 11 checksum
  waddr   in   3  target word address for read/write
  wdata   in   8  write data
  busy    out  1  high from the cycle after acceptance until the return to IDLE
  done    out  1  one-cycle completion pulse
  rdata   out  8  read or checksum result
  m_RW    out  1  memory read/write control: 1 = read (safe idle level), 0 = write
  m_addr  out  3  memory address (bit 0 = addr0)
  m_i     out  8  memory write data
  m_o     in   8  memory read data, combinational from m_addr

Function
REQ-003 States SHALL be IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_CAP, FIN.
REQ-004 Acceptance: req=1 and state IDLE at an edge latches cmd, waddr and wdata; busy=1 from the next cycle.
REQ-005 req while busy=1 SHALL be ignored: no queuing, no error.
REQ-006 m_RW SHALL be 0 only in W_STROBE; in every other state, including IDLE and reset, it SHALL be 1.
REQ-007 m_addr and m_i SHALL be stable through W_SETUP, W_STROBE and W_HOLD, giving one cycle of setup and one of hold around the strobe.
REQ-008 Write path: IDLE -> W_SETUP -> W_STROBE -> W_HOLD -> FIN -> IDLE; done in the 4th cycle after acceptance.
REQ-009 Read path: IDLE -> R_ADDR -> R_CAP -> FIN -> IDLE.
  - In R_CAP, rdata <= m_o.
  - done SHALL be asserted in the 3rd cycle after acceptance.
  - rdata SHALL be valid when done=1.
REQ-010 Clear-all: 3-bit word counter starts at 0 and m_i=8'h00.
  - Each word runs W_SETUP/W_STROBE/W_HOLD.
  - From W_HOLD: counter==7 -> FIN; otherwise counter+1 -> W_SETUP.
  - Total 24 cycles plus FIN; done in cycle 25 after acceptance.
REQ-011 Checksum: rdata <= 0 at acceptance; counter starts at 0.
  - Each word runs R_ADDR, then R_CAP with rdata <= rdata XOR m_o.
  - From R_CAP: counter==7 -> FIN; otherwise counter+1 -> R_ADDR.
  - done in cycle 17 after acceptance.
REQ-012 For clear-all and checksum, m_addr SHALL equal the counter and waddr SHALL be ignored.
REQ-013 rdata SHALL be unchanged by write and clear-all, and SHALL hold its value between commands.
REQ-014 FIN SHALL last exactly one cycle with done=1 and busy=1; IDLE follows with busy=0, so back-to-back acceptance is possible on the edge ending FIN+1.
REQ-015 The counter SHALL NOT wrap past 7 within a command; the next clear-all or checksum restarts at 0.
REQ-016 In IDLE, m_addr and m_i SHALL hold their last driven values.

Reset
REQ-017 While rst=1: state IDLE, busy=0, done=0, rdata=8'h00, m_RW=1, m_addr=3'b000, m_i=8'h00, counter=0.
REQ-018 rst asserted mid-command SHALL abort the command immediately with no done pulse.
  - m_RW SHALL return to 1 asynchronously, so a write in W_STROBE may be truncated.
  - Words already written SHALL stay written.
REQ-019 After rst deasserts, the first acceptance is possible on the first clk edge.

Verification
REQ-020 Write then read: write addr 5 data 8'hA7, then read addr 5 -> done 4 cycles and 3 cycles after acceptance respectively; rdata=8'hA7; m_RW=0 for exactly one cycle.
REQ-021 Write 8'h01,02,04,08,10,20,40,80 to addr 0..7, then checksum -> done 17 cycles after acceptance, rdata=8'hFF.
REQ-022 Clear-all, then read addr 3 -> rdata=8'h00; clear-all done 25 cycles after acceptance; m_addr steps 0..7; eight m_RW=0 pulses.
REQ-023 req held high with cmd=read during a clear-all -> ignored until IDLE; one read then accepted on the edge ending the cycle after FIN.
REQ-024 rst pulsed during W_STROBE of a clear-all at word 4 -> m_RW=1 immediately, no done, busy=0; words 0..3 read back 8'h00.

Source files
------------

// File: rtl/mem_ctrl.sv
// Command sequencer for an 8x8 asynchronous SRAM: single read/write, clear-all and XOR checksum.
// Writes get one cycle of address/data setup and one of hold around a single-cycle m_RW=0 strobe.
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] cmd,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       m_RW,
  output logic [2:0] m_addr,
  output logic [7:0] m_i,
  input  logic [7:0] m_o
);

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_CLR  = 2'b10;
  localparam logic [1:0] CMD_CSUM = 2'b11;

  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_CAP, FIN} state_t;

  state_t     state, nxt;
  logic [1:0] op;
  logic [2:0] cnt;
  logic       last;

  assign last = (cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // m_RW is decoded from state only, so the async reset pulls it high at once
  always_comb begin
    nxt  = state;
    busy = (state != IDLE);
    done = (state == FIN);
    m_RW = (state != W_STROBE);
    case (state)
      IDLE:     if (req) nxt = (cmd == CMD_RD || cmd == CMD_CSUM) ? R_ADDR : W_SETUP;
      W_SETUP:  nxt = W_STROBE;
      W_STROBE: nxt = W_HOLD;
      W_HOLD:   nxt = (op == CMD_CLR && !last) ? W_SETUP : FIN;
      R_ADDR:   nxt = R_CAP;
      R_CAP:    nxt = (op == CMD_CSUM && !last) ? R_ADDR : FIN;
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op     <= CMD_RD;
      cnt    <= 3'd0;
      rdata  <= 8'h00;
      m_addr <= 3'd0;
      m_i    <= 8'h00;
    end else begin
      case (state)
        IDLE: if (req) begin
          op  <= cmd;
          cnt <= 3'd0;
          case (cmd)
            CMD_RD:   m_addr <= waddr;
            CMD_WR:   begin m_addr <= waddr; m_i <= wdata; end
            CMD_CLR:  begin m_addr <= 3'd0;  m_i <= 8'h00; end
            CMD_CSUM: begin m_addr <= 3'd0;  rdata <= 8'h00; end
            default:  ;
          endcase
        end
        W_HOLD: if (op == CMD_CLR && !last) begin
          cnt    <= cnt + 3'd1;
          m_addr <= cnt + 3'd1;
        end
        R_CAP: begin
          if (op == CMD_CSUM) begin
            rdata <= rdata ^ m_o;
            if (!last) begin
              cnt    <= cnt + 3'd1;
              m_addr <= cnt + 3'd1;
            end
          end else begin
            rdata <= m_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with an 8x8 SRAM model that commits a write on the clock edge ending m_RW=0.
module tb_mem_ctrl;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, CLR = 2'b10, CSUM = 2'b11;

  logic       clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [2:0] waddr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, m_RW;
  logic [7:0] rdata, m_i, m_o;
  logic [2:0] m_addr;

  logic [7:0] mem [8];
  logic [2:0] pa [8];
  int cmp = 0, bad = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .m_RW(m_RW), .m_addr(m_addr),
    .m_i(m_i), .m_o(m_o)
  );

  always #5 clk = ~clk;

  assign m_o = mem[m_addr];
  always @(posedge clk) if (!m_RW) mem[m_addr] <= m_i;

  // Issues one command (caller is idle and clear of an edge) and runs it to the idle
  // cycle after FIN; cyc = cycle of done after acceptance, -1 on timeout.
  task automatic run_cmd(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d,
                         output int cyc, output int pulses);
    req = 1'b1; cmd = c; waddr = a; wdata = d;
    @(posedge clk); #1; req = 1'b0;
    cyc = 1; pulses = 0;
    while (!done && cyc < 100) begin
      if (!m_RW) begin
        if (pulses < 8) pa[pulses] = m_addr;
        pulses++;
      end
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 100) cyc = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int cyc, p;
    #12;
    cmp += 6;
    if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)   begin bad++; $display("FAIL rst_done got %b want 0", done); end
    if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got %h want 00", rdata); end
    if (m_RW !== 1'b1)   begin bad++; $display("FAIL rst_m_RW got %b want 1", m_RW); end
    if (m_addr !== 3'd0) begin bad++; $display("FAIL rst_m_addr got %0d want 0", m_addr); end
    if (m_i !== 8'h00)   begin bad++; $display("FAIL rst_m_i got %h want 00", m_i); end
    @(negedge clk); rst = 1'b0;
    run_cmd(WR, 3'd1, 8'h5A, cyc, p);
    cmp += 2;
    if (cyc !== 4) begin bad++; $display("FAIL first_wr_done_cyc got %0d want 4", cyc); end
    if (mem[1] !== 8'h5A) begin bad++; $display("FAIL first_wr_mem got %h want 5a", mem[1]); end
  endtask

  task automatic test_write_read();
    int cyc, p;
    run_cmd(WR, 3'd5, 8'hA7, cyc, p);
    cmp += 4;
    if (cyc !== 4) begin bad++; $display("FAIL wr_done_cyc got %0d want 4", cyc); end
    if (p !== 1)   begin bad++; $display("FAIL wr_strobes got %0d want 1", p); end
    if (pa[0] !== 3'd5) begin bad++; $display("FAIL wr_strobe_addr got %0d want 5", pa[0]); end
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle_busy got %b want 0", busy); end
    run_cmd(RD, 3'd5, 8'h00, cyc, p);
    cmp += 3;
    if (cyc !== 3)       begin bad++; $display("FAIL rd_done_cyc got %0d want 3", cyc); end
    if (rdata !== 8'hA7) begin bad++; $display("FAIL rd_data got %h want a7", rdata); end
    if (p !== 0)         begin bad++; $display("FAIL rd_strobes got %0d want 0", p); end
    run_cmd(WR, 3'd2, 8'h3C, cyc, p);
    cmp += 2;
    if (rdata !== 8'hA7) begin bad++; $display("FAIL rdata_kept_by_wr got %h want a7", rdata); end
    if (m_i !== 8'h3C)   begin bad++; $display("FAIL m_i_hold_idle got %h want 3c", m_i); end
  endtask

  task automatic test_checksum();
    int cyc, p;
    for (int i = 0; i < 8; i++) run_cmd(WR, 3'(i), 8'(1 << i), cyc, p);
    run_cmd(CSUM, 3'd6, 8'h00, cyc, p);
    cmp += 3;
    if (cyc !== 17)      begin bad++; $display("FAIL csum_done_cyc got %0d want 17", cyc); end
    if (rdata !== 8'hFF) begin bad++; $display("FAIL csum_onehot got %h want ff", rdata); end
    if (p !== 0)         begin bad++; $display("FAIL csum_strobes got %0d want 0", p); end
    run_cmd(WR, 3'd0, 8'h0F, cyc, p);
    run_cmd(CSUM, 3'd0, 8'h00, cyc, p);
    cmp += 1;
    if (rdata !== 8'hF1) begin bad++; $display("FAIL csum_pattern2 got %h want f1", rdata); end
  endtask

  task automatic test_clear();
    int cyc, p;
    logic ok;
    run_cmd(CLR, 3'd5, 8'hEE, cyc, p);
    cmp += 4;
    if (cyc !== 25) begin bad++; $display("FAIL clr_done_cyc got %0d want 25", cyc); end
    if (p !== 8)    begin bad++; $display("FAIL clr_strobes got %0d want 8", p); end
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (pa[i] !== 3'(i)) ok = 1'b0;
    if (!ok) begin bad++; $display("FAIL clr_addr_steps got %0d,%0d,%0d want 0,1,2", pa[0], pa[1], pa[2]); end
    if (rdata !== 8'hF1) begin bad++; $display("FAIL rdata_kept_by_clr got %h want f1", rdata); end
    run_cmd(RD, 3'd3, 8'h00, cyc, p);
    cmp += 1;
    if (rdata !== 8'h00) begin bad++; $display("FAIL clr_rd3 got %h want 00", rdata); end
    run_cmd(WR, 3'd7, 8'h99, cyc, p);
    run_cmd(RD, 3'd7, 8'h00, cyc, p);
    cmp += 1;
    if (rdata !== 8'h99) begin bad++; $display("FAIL rd7_after_clr got %h want 99", rdata); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    req = 1'b1; cmd = CLR; waddr = 3'd0;
    @(posedge clk); #1;
    cmd = RD; waddr = 3'd7;
    cyc = 1;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    cmp += 1;
    if (cyc !== 25) begin bad++; $display("FAIL b2b_clr_done_cyc got %0d want 25", cyc); end
    @(posedge clk); #1;
    cmp += 1;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    @(posedge clk); #1;
    req = 1'b0;
    cmp += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_rd_accept got %b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    cmp += 2;
    if (cyc !== 3)       begin bad++; $display("FAIL b2b_rd_done_cyc got %0d want 3", cyc); end
    if (rdata !== 8'h00) begin bad++; $display("FAIL b2b_rd_data got %h want 00", rdata); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp += 1;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_single_rd got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int cyc, p, seen;
    for (int i = 0; i < 5; i++) run_cmd(WR, 3'(i), 8'h11 + 8'(i), cyc, p);
    req = 1'b1; cmd = CLR;
    @(posedge clk); #1; req = 1'b0;
    for (int i = 1; i < 14; i++) begin @(posedge clk); #1; end
    cmp += 1;
    if (m_RW !== 1'b0 || m_addr !== 3'd4) begin
      bad++; $display("FAIL abort_strobe4 got rw=%b addr=%0d want rw=0 addr=4", m_RW, m_addr);
    end
    #2 rst = 1'b1;
    #1;
    cmp += 3;
    if (m_RW !== 1'b1) begin bad++; $display("FAIL abort_m_RW got %b want 1", m_RW); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL abort_done got %b want 0", done); end
    @(posedge clk); @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1; if (done) seen++; end
    cmp += 1;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", seen); end
    for (int i = 0; i < 4; i++) begin
      run_cmd(RD, 3'(i), 8'h00, cyc, p);
      cmp += 1;
      if (rdata !== 8'h00) begin bad++; $display("FAIL abort_word%0d got %h want 00", i, rdata); end
    end
    run_cmd(RD, 3'd4, 8'h00, cyc, p);
    cmp += 1;
    if (rdata !== 8'h15) begin bad++; $display("FAIL abort_word4_kept got %h want 15", rdata); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_checksum();
    test_clear();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
